core_mem_copy_master: RTL

CORE_MEM_COPY_MASTER -- requirements
Module: core_mem_copy_master

---
 rtl/core_mem_copy_master.sv | 109 ++++++++++
 1 files changed

// File: rtl/core_mem_copy_master.sv
// Word-by-word memory copy master for a fixed-latency-1 memory slave.
// Each word costs three cycles: issue read, capture read data, issue write.
module core_mem_copy_master #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_done,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   src_reg, dst_reg;
  logic [ADDR_W:0]     len_reg, words_done_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W-1:0]   offset;

  assign count_inc = words_done_reg + (ADDR_W+1)'(1);
  // Low bits only: address arithmetic wraps modulo the memory size.
  assign offset    = words_done_reg[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      words_done_reg <= '0;
      data_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            src_reg        <= cmd_src;
            dst_reg        <= cmd_dst;
            len_reg        <= cmd_len;
            words_done_reg <= '0;
          end
        end
        CAPT:    data_reg       <= readdata;
        WRITE:   words_done_reg <= count_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (cmd_valid) state_next = (cmd_len == '0) ? DONE : READ;
      READ:  state_next = abort ? IDLE : CAPT;
      CAPT:  state_next = abort ? IDLE : WRITE;
      // An abort here still lets the in-flight write land and be counted.
      WRITE: begin
        if (abort)                  state_next = IDLE;
        else if (count_inc < len_reg) state_next = READ;
        else                        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    case (state_reg)
      READ: begin
        chipselect = 1'b1;
        address    = src_reg + offset;
      end
      WRITE: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = dst_reg + offset;
      end
      default: ;
    endcase
  end

  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg == READ) || (state_reg == CAPT) || (state_reg == WRITE);
  assign done       = (state_reg == DONE);
  assign words_done = words_done_reg;
  assign writedata  = data_reg;
  assign byteenable = '1;
  assign clken      = 1'b1;

endmodule
